lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the memory stage of the pipeline, sitting directly upstream of the data memory. It accepts one byte-addressed load/store request at a time from the execute stage and drives the data memory's word-addressed `wen`/`ren`/`addr`/`write_data` port. It returns sign- or zero-extended load data to writeback. The data memory has no byte enables, so byte and halfword stores are done as a read-modify-write sequence.

## Interface
- `AW`, default `` `ISIZE ``: byte-address width.
- `DW`, default `` `DSIZE ``: data width; must be 32.
- `clk`  in  1: single clock; everything samples on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: a request is present.
- `req_ready`  out  1: the unit can accept; a request transfers when `req_valid & req_ready`.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned`  in  1: zero-extend loads.
- `req_addr`  in  AW: byte address.
- `req_wdata`  in  DW: store data, right-aligned.
- `req_rd`  in  5: destination register tag.
- `resp_valid`  out  1: one-cycle pulse carrying the load result.
- `resp_rd`  out  5: tag echoed from the request.
- `resp_data`  out  DW: extended load data.
- `misalign`  out  1: qualifies `resp_valid` (trap build only).
- `dm_wen`, `dm_ren`  out  1: memory strobes.
- `dm_addr`  out  AW: word address, equal to the byte address shifted right by 2.
- `dm_wdata`  out  DW: memory write data.
- `dm_rdata`  in  DW: memory read data, valid in the cycle after `dm_ren` and held until the next `dm_ren`.

## Operation
- Request capture: address, size, store data, tag, `req_we` and `req_unsigned` are registered on accept.
- FSM states: IDLE, RD_ISSUE, LD_WAIT, MERGE, WR.
  - IDLE + load → RD_ISSUE → LD_WAIT → IDLE.
  - IDLE + word store → WR → IDLE.
  - IDLE + sub-word store → RD_ISSUE → MERGE → WR → IDLE.
- `dm_ren` is 1 only in RD_ISSUE. `dm_wen` is 1 only in WR. Both are never high together.
- `dm_addr` and `dm_wdata` are registered, and equal 0 outside RD_ISSUE and WR.
- Byte lanes are little-endian:
  - byte k = `addr[1:0]`, occupying bits 8k+7:8k;
  - half h = `addr[1]`, occupying bits 16h+15:16h.
- Load extension: sign-extend from the lane MSB unless `req_unsigned` is set. Word loads ignore `req_unsigned`.
- Store merge (MERGE state): take `dm_rdata`, replace only the addressed lane with the low 8 or 16 bits of the store data, and register the result as `dm_wdata` for WR.
- Stores never assert `resp_valid`.
- `req_ready` = (state == IDLE) & !`rst`.
- Reset: state IDLE; all outputs 0, including `req_ready`. No memory access is issued while `rst` is high, because memory initialises during reset.
- Reset mid-operation: the sequence is abandoned; no `dm_wen` is issued afterward and a pending response is dropped.

## Timing
Accept is the edge ending cycle 0.
- Load:
  - `dm_ren` in cycle 1.
  - `dm_rdata` is sampled in cycle 2.
  - `resp_valid` is high in cycle 3 only.
  - `req_ready` returns in cycle 3, so back-to-back loads issue every 3 cycles.
- Word store: `dm_wen` in cycle 1; ready in cycle 2.
- Sub-word store: `dm_ren` in cycle 1, merge in cycle 2, `dm_wen` in cycle 3, ready in cycle 4.
- A load accepted in the cycle following a store's WR observes the stored data.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- A request is misaligned when it is a half with `addr[0]`=1, or a word with `addr[1:0]` ≠ 0.
- Defined:
  - a misaligned request of either type is accepted without any memory access;
  - the FSM stays in IDLE;
  - next cycle `resp_valid`=1, `misalign`=1, `resp_data`=0, with `resp_rd` echoed.
- Undefined: offending low address bits are forced to 0 (natural alignment) and the access proceeds normally; `misalign` is tied to 0.

## Structure
- Shared defines file:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - FSM state codes;
  - `` `ISIZE `` and `` `DSIZE `` (already present).
- One combinational sub-module, `lsu_lane`, handles lane extract/extend for loads and lane merge for stores. It is instantiated once; the FSM lives in the top module.

## Test plan
Memory is preloaded with word 0x4 = 0x8899AABB.
- Word load from 0x10:
  - `dm_ren` with `dm_addr`=0x4 in cycle 1 only;
  - cycle 3 `resp_valid`, `resp_data`=0x8899AABB, tag echoed.
- Sub-word loads:
  - byte 0x12 signed → 0xFFFFFF99;
  - byte 0x12 unsigned → 0x00000099;
  - half 0x12 signed → 0xFFFF8899.
- Byte store 0x5A to 0x11:
  - `dm_ren` in cycle 1, `dm_wen` in cycle 3 with `dm_wdata`=0x88995ABB;
  - `req_ready` low in cycles 1–3;
  - a following word load returns 0x88995ABB.
- Word load at 0x12:
  - with the macro: `resp_valid`+`misalign` in cycle 1, resp_data 0, no dm strobes;
  - without the macro: reads word 0x4 normally.
- Reset during MERGE of a byte store:
  - no `dm_wen`, memory unchanged, no `resp_valid`;
  - `req_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Word store of 0x01234567 to 0x10, then an immediate load of 0x10 → `resp_data`=0x01234567.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: shared definitions for the memory-stage load/store unit.
// Holds the address/data width defaults, the access-size encodings, the FSM
// state codes and small helpers for lane alignment.
`ifndef ISIZE
`define ISIZE 32
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

package lsu_mem_stage_pkg;

    // Access size encodings carried on req_size; 2'b11 behaves as a word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_LD_WAIT  = 3'd2,
        ST_MERGE    = 3'd3,
        ST_WR       = 3'd4
    } lsu_state_e;

    // Word accesses are any size with the upper encoding bit set
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    // A half needs an even address, a word needs a word-aligned address
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Clear the low address bits that would make an access misaligned
    function automatic logic [1:0] align_offset(input logic [1:0] size,
                                                input logic [1:0] off);
        logic [1:0] res;
        case (size)
            SZ_BYTE: res = off;
            SZ_HALF: res = {off[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_lane.sv
// lsu_lane: little-endian byte-lane steering for the load/store unit.
// Extracts and sign/zero-extends the addressed lane for loads, and merges the
// store lane into a read word for read-modify-write stores.
module lsu_lane
    import lsu_mem_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    size_i,
    input  logic [1:0]    offset_i,
    input  logic          unsigned_i,
    input  logic [DW-1:0] rdata_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] load_data_o,
    output logic [DW-1:0] merge_data_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Pick the addressed lane out of the read word and extend it to full width
    always_comb begin
        byteLane    = rdata_i[{offset_i, 3'b000} +: 8];
        halfLane    = rdata_i[{offset_i[1], 4'b0000} +: 16];
        load_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: load_data_o = unsigned_i ? {{(DW-8){1'b0}}, byteLane}
                                              : {{(DW-8){byteLane[7]}}, byteLane};
            SZ_HALF: load_data_o = unsigned_i ? {{(DW-16){1'b0}}, halfLane}
                                              : {{(DW-16){halfLane[15]}}, halfLane};
            default: load_data_o = rdata_i;
        endcase
    end

    // Overwrite only the addressed lane of the read word with the store data
    always_comb begin
        merge_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: merge_data_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_HALF: merge_data_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit in front of a word-addressed
// data memory that has no byte enables, so byte/half stores are done as
// read-modify-write. One request is in flight at a time.
// Build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned requests get an
// immediate misalign response with no memory access; otherwise the offending
// low address bits are cleared and the access proceeds.
`ifndef ISIZE
`define ISIZE 32
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int AW = `ISIZE,
    parameter int DW = `DSIZE
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [4:0]    req_rd_i,
    output logic          resp_valid_o,
    output logic [4:0]    resp_rd_o,
    output logic [DW-1:0] resp_data_o,
    output logic          misalign_o,
    output logic          dm_wen_o,
    output logic          dm_ren_o,
    output logic [AW-1:0] dm_addr_o,
    output logic [DW-1:0] dm_wdata_o,
    input  logic [DW-1:0] dm_rdata_i
);

    lsu_state_e    state_q, state_d;

    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic [DW-1:0] wdata_q;
    logic [4:0]    rd_q;
    logic          we_q;
    logic          unsigned_q;

    logic          accept;
    logic          trapTake;
    logic [AW-1:0] alignedAddr;
    logic [AW-1:0] curAddr;
    logic [DW-1:0] laneLoad;
    logic [DW-1:0] laneMerge;

    logic          dmRen_q, dmRen_d;
    logic          dmWen_q, dmWen_d;
    logic [AW-1:0] dmAddr_q, dmAddr_d;
    logic [DW-1:0] dmWdata_q, dmWdata_d;
    logic          respValid_q, respValid_d;
    logic [4:0]    respRd_q, respRd_d;
    logic [DW-1:0] respData_q, respData_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic          misalign_q, misalign_d;
`endif

    assign req_ready_o = (state_q == ST_IDLE) & ~rst_i;
    assign accept      = req_valid_i & req_ready_o;
    assign alignedAddr = {req_addr_i[AW-1:2], align_offset(req_size_i, req_addr_i[1:0])};
    // On the accept edge the captured address is not yet registered
    assign curAddr     = (state_q == ST_IDLE) ? alignedAddr : addr_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trapTake = accept & is_misaligned(req_size_i, req_addr_i[1:0]);
`else
    assign trapTake = 1'b0;
`endif

    lsu_lane #(.DW(DW)) u_lane (
        .size_i       (size_q),
        .offset_i     (addr_q[1:0]),
        .unsigned_i   (unsigned_q),
        .rdata_i      (dm_rdata_i),
        .wdata_i      (wdata_q),
        .load_data_o  (laneLoad),
        .merge_data_o (laneMerge)
    );

    // Capture the request fields when it is accepted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            wdata_q    <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= alignedAddr;
            size_q     <= req_size_i;
            wdata_q    <= req_wdata_i;
            rd_q       <= req_rd_i;
            we_q       <= req_we_i;
            unsigned_q <= req_unsigned_i;
        end
    end

    // State register; reset abandons any sequence in progress
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: loads and sub-word stores read first, word stores write directly
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !trapTake) begin
                    if (req_we_i && is_word(req_size_i)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: state_d = we_q ? ST_MERGE : ST_LD_WAIT;
            ST_LD_WAIT:  state_d = ST_IDLE;
            ST_MERGE:    state_d = ST_WR;
            ST_WR:       state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the state being entered
    always_comb begin
        dmRen_d     = (state_d == ST_RD_ISSUE);
        dmWen_d     = (state_d == ST_WR);
        dmAddr_d    = '0;
        dmWdata_d   = '0;
        respValid_d = 1'b0;
        respRd_d    = '0;
        respData_d  = '0;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        if (dmRen_d || dmWen_d) begin
            dmAddr_d = curAddr >> 2;
        end
        if (dmWen_d) begin
            dmWdata_d = (state_q == ST_MERGE) ? laneMerge : req_wdata_i;
        end
        if (state_q == ST_LD_WAIT) begin
            respValid_d = 1'b1;
            respRd_d    = rd_q;
            respData_d  = laneLoad;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (trapTake) begin
            respValid_d = 1'b1;
            respRd_d    = req_rd_i;
            misalign_d  = 1'b1;
        end
`endif
    end

    // Output registers, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmRen_q     <= 1'b0;
            dmWen_q     <= 1'b0;
            dmAddr_q    <= '0;
            dmWdata_q   <= '0;
            respValid_q <= 1'b0;
            respRd_q    <= '0;
            respData_q  <= '0;
        end else begin
            dmRen_q     <= dmRen_d;
            dmWen_q     <= dmWen_d;
            dmAddr_q    <= dmAddr_d;
            dmWdata_q   <= dmWdata_d;
            respValid_q <= respValid_d;
            respRd_q    <= respRd_d;
            respData_q  <= respData_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misalign flag accompanies the trap response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
    assign misalign_o = misalign_q & ~rst_i;
`else
    assign misalign_o = 1'b0;
`endif

    // Outputs are forced low during reset so memory sees no strobe while it initialises
    assign dm_ren_o     = dmRen_q & ~rst_i;
    assign dm_wen_o     = dmWen_q & ~rst_i;
    assign dm_addr_o    = rst_i ? '0 : dmAddr_q;
    assign dm_wdata_o   = rst_i ? '0 : dmWdata_q;
    assign resp_valid_o = respValid_q & ~rst_i;
    assign resp_rd_o    = rst_i ? '0 : respRd_q;
    assign resp_data_o  = rst_i ? '0 : respData_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: self-checking bench for lsu_mem_stage. A cycle-indexed
// expectation table is filled from the access rules whenever a request is
// accepted, and one negedge process compares every output against it.
`timescale 1ns/1ps
module tb_lsu_mem_stage;

    localparam int NC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        req_ready, resp_valid, misalign, dm_wen, dm_ren;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data, dm_addr, dm_wdata;
    logic [31:0] dm_rdata = '0;
    logic [31:0] dmem [64];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    bit        eRen [NC];
    bit        eWen [NC];
    bit        eRv  [NC];
    bit        eMis [NC];
    bit        eBusy[NC];
    bit [31:0] eAddr[NC];
    bit [31:0] eWdata[NC];
    bit [31:0] eData[NC];
    bit [4:0]  eRd  [NC];
    bit [31:0] mm   [64];

    lsu_mem_stage #(.AW(32), .DW(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_rd_i       (req_rd),
        .resp_valid_o   (resp_valid),
        .resp_rd_o      (resp_rd),
        .resp_data_o    (resp_data),
        .misalign_o     (misalign),
        .dm_wen_o       (dm_wen),
        .dm_ren_o       (dm_ren),
        .dm_addr_o      (dm_addr),
        .dm_wdata_o     (dm_wdata),
        .dm_rdata_i     (dm_rdata)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter; cycle n is the period after the n-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Word-addressed data memory: read data appears the cycle after dm_ren and is held
    always @(posedge clk) begin
        if (dm_wen) dmem[dm_addr[5:0]] <= dm_wdata;
        if (dm_ren) dm_rdata <= dmem[dm_addr[5:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load result from a memory word using shift/mask arithmetic
    function automatic bit [31:0] loadModel(bit [31:0] w, bit [1:0] size, bit uns, bit [1:0] off);
        bit [31:0] v;
        if (size == 2'b00) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (w >> (16 * off[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Sub-word store result from a memory word using a shifted lane mask
    function automatic bit [31:0] mergeModel(bit [31:0] w, bit [31:0] wd, bit [1:0] size, bit [1:0] off);
        bit [31:0] mask;
        int sh;
        sh   = (size == 2'b00) ? 8 * off : 16 * off[1];
        mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    logic [31:0] lastData;

    // Per-cycle comparison of every DUT output against the expectation table
    always @(negedge clk) begin
        if (cyc < NC) begin
            checkOutput("req_ready", req_ready, {31'b0, !rst && !eBusy[cyc]});
            checkOutput("dm_ren", dm_ren, eRen[cyc]);
            checkOutput("dm_wen", dm_wen, eWen[cyc]);
            checkOutput("dm_addr", dm_addr, eAddr[cyc]);
            checkOutput("dm_wdata", dm_wdata, eWdata[cyc]);
            checkOutput("resp_valid", resp_valid, eRv[cyc]);
            checkOutput("misalign", misalign, eMis[cyc]);
            if (eRv[cyc]) begin
                checkOutput("resp_data", resp_data, eData[cyc]);
                checkOutput("resp_rd", resp_rd, eRd[cyc]);
            end
            if (!rst && eWen[cyc]) mm[eAddr[cyc][5:0]] = eWdata[cyc];
        end
    end

    // Drive one request when the unit is ready and schedule its expected outputs
    task automatic applyStimulus(input bit we, input bit [1:0] size, input bit uns,
                                 input bit [31:0] addr, input bit [31:0] wd, input bit [4:0] rd);
        int n = 0;
        int c;
        bit mis;
        bit [1:0] off;
        bit [31:0] wa;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("ready_timeout", req_ready, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        c   = cyc;
        mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            eRv[c+1] = 1'b1; eMis[c+1] = 1'b1; eData[c+1] = '0; eRd[c+1] = rd;
        end else
`endif
        begin
            if (size[1])           off = 2'b00;
            else if (size == 2'b01) off = {addr[1], 1'b0};
            else                   off = addr[1:0];
            wa = addr >> 2;
            if (!we) begin
                eRen[c+1] = 1'b1; eAddr[c+1] = wa;
                eBusy[c+1] = 1'b1; eBusy[c+2] = 1'b1;
                eRv[c+3] = 1'b1; eRd[c+3] = rd;
                eData[c+3] = loadModel(mm[wa[5:0]], size, uns, off);
            end else if (size[1]) begin
                eWen[c+1] = 1'b1; eAddr[c+1] = wa; eWdata[c+1] = wd; eBusy[c+1] = 1'b1;
            end else begin
                eRen[c+1] = 1'b1; eAddr[c+1] = wa;
                eBusy[c+1] = 1'b1; eBusy[c+2] = 1'b1; eBusy[c+3] = 1'b1;
                eWen[c+3] = 1'b1; eAddr[c+3] = wa;
                eWdata[c+3] = mergeModel(mm[wa[5:0]], wd, size, off);
            end
        end
        if (mis) $display("[TB] note: misaligned request at %h", addr);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait (bounded) for the next response and compare it with a literal
    task automatic waitResp(input string name, input bit [31:0] expData, input bit expMis);
        int n = 0;
        while (n < 8) begin
            @(negedge clk);
            if (resp_valid === 1'b1) break;
            n++;
        end
        if (n >= 8) checkOutput({name, "_timeout"}, resp_valid, 32'd1);
        else begin
            lastData = resp_data;
            checkOutput(name, lastData, expData);
            checkOutput({name, "_mis"}, misalign, expMis);
        end
    endtask

    // Assert reset at the start of a cycle and drop everything scheduled from then on
    task automatic doReset(input int n);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = cyc; i < NC; i++) begin
            eRen[i] = 0; eWen[i] = 0; eRv[i] = 0; eMis[i] = 0; eBusy[i] = 0;
            eAddr[i] = '0; eWdata[i] = '0; eData[i] = '0; eRd[i] = '0;
        end
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Bound the whole run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        for (int i = 0; i < 64; i++) begin
            dmem[i] = '0;
            mm[i]   = '0;
        end
        dmem[4] = 32'h8899_AABB;
        mm[4]   = 32'h8899_AABB;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd3);
        waitResp("ld_word_10", 32'h8899_AABB, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 5'd4);
        waitResp("ld_byte_s", 32'hFFFF_FF99, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 5'd5);
        waitResp("ld_byte_u", 32'h0000_0099, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 5'd6);
        waitResp("ld_half_s", 32'hFFFF_8899, 1'b0);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A, 5'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7);
        waitResp("ld_after_sb", 32'h8899_5ABB, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 5'd8);
        waitResp("ld_mis_trap", 32'h0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'h1111, 5'd9);
        waitResp("st_mis_trap", 32'h0, 1'b1);
`else
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 5'd8);
        waitResp("ld_mis_align", 32'h8899_5ABB, 1'b0);
`endif

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_00EE, 5'd0);
        doReset(2);
        @(negedge clk);
        checkOutput("ready_after_rst", req_ready, 32'd1);
        checkOutput("mem_unchanged", dmem[4], 32'h8899_5ABB);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd10);
        waitResp("ld_after_rst", 32'h8899_5ABB, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0123_4567, 5'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd11);
        waitResp("ld_after_sw", 32'h0123_4567, 1'b0);

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 5'd0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 5'd12);
        waitResp("ld_half_u", 32'h0000_BEEF, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 5'd13);
        waitResp("ld_byte_13", 32'hFFFF_FFBE, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 5'd14);
        waitResp("ld_word_sz3", 32'hBEEF_4567, 1'b0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
